int_to_fp_pipe: RTL and testbench



---
 rtl/int_to_fp_pkg.sv | 26 ++
 rtl/lzc_count.sv | 27 ++
 rtl/int_to_fp_pipe.sv | 170 +++++++++++++++++
 tb/tb_int_to_fp_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_to_fp_pkg.sv
// Shared definitions for the integer-to-float converter.
// Provides the float format helpers (bias, total width, field positions)
// used by the pipeline top; no ports.
package int_to_fp_pkg;

   // Field positions of the default single-precision layout.
   localparam int SIGN_POS = 31;
   localparam int EXP_LSB  = 23;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int fp_w(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int fp_sign_pos(input int exp_w, input int man_w);
      return exp_w + man_w;
   endfunction

   function automatic int fp_exp_lsb(input int man_w);
      return man_w;
   endfunction

endpackage

// File: rtl/lzc_count.sv
// Combinational leading-zero counter.
// Ports:
//   in_vec   - value to scan (W bits)
//   cnt      - number of leading zeros; equals W when in_vec is zero
//   all_zero - high when in_vec is zero
module lzc_count #(
   parameter int W     = 32,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     in_vec,
   output logic [CNT_W-1:0] cnt,
   output logic             all_zero
);

   // Ascending scan: the highest set bit is the last to write cnt.
   always_comb begin
      cnt = CNT_W'(W);
      for (int i = 0; i < W; i++) begin
         if (in_vec[i]) begin
            cnt = CNT_W'(W - 1 - i);
         end
      end
   end

   assign all_zero = ~|in_vec;

endmodule

// File: rtl/int_to_fp_pipe.sv
// Three-stage pipelined integer to binary-float converter with
// round-to-nearest-even and an inexact flag. Signed or unsigned per
// transaction. Whole pipe advances together when the output is free.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_valid/in_ready      - input handshake
//   in_data, in_signed     - operand and its interpretation
//   out_valid/out_ready    - output handshake
//   out_data, out_inexact  - {sign, exponent, fraction} and rounding flag
module int_to_fp_pipe
   import int_to_fp_pkg::*;
#(
   parameter int INT_W = 32,
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [INT_W-1:0]              in_data,
   input  logic                          in_signed,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [fp_w(EXP_W, MAN_W)-1:0] out_data,
   output logic                          out_inexact
);

   localparam int FP_W  = fp_w(EXP_W, MAN_W);
   localparam int LZ_W  = $clog2(INT_W + 1);
   localparam int EXT_W = INT_W + MAN_W + 1;
   localparam int BIAS  = fp_bias(EXP_W);
   localparam int S_POS = fp_sign_pos(EXP_W, MAN_W);
   localparam int E_LSB = fp_exp_lsb(MAN_W);

   logic adv;

   logic             s1_valid_q, s1_valid_d;
   logic             s1_sign_q, s1_sign_d;
   logic [INT_W-1:0] s1_mag_q, s1_mag_d;
   logic             s1_zero_q, s1_zero_d;

   logic [LZ_W-1:0]  lz_cnt;
   logic             lz_zero;

   logic             s2_valid_q, s2_valid_d;
   logic             s2_sign_q, s2_sign_d;
   logic             s2_zero_q, s2_zero_d;
   logic [INT_W-1:0] s2_norm_q, s2_norm_d;
   logic [LZ_W-1:0]  s2_msb_q, s2_msb_d;

   logic             out_valid_q, out_valid_d;
   logic [FP_W-1:0]  out_data_q, out_data_d;
   logic             out_inexact_q, out_inexact_d;

   logic [EXT_W-1:0] ext;
   logic [MAN_W-1:0] frac;
   logic             guard, sticky, round_up, is_zero;
   logic [MAN_W:0]   frac_sum;
   logic [EXP_W-1:0] exp_f;

   assign adv = !out_valid_q || out_ready;

   // S1: sign and magnitude; the most negative value wraps to 2^(INT_W-1).
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_mag_d   = s1_mag_q;
      s1_zero_d  = s1_zero_q;
      if (adv) begin
         s1_valid_d = in_valid;
         s1_sign_d  = in_signed & in_data[INT_W-1];
         s1_mag_d   = s1_sign_d ? (~in_data + INT_W'(1)) : in_data;
         s1_zero_d  = (s1_mag_d == '0);
      end
   end

   lzc_count #(.W(INT_W), .CNT_W(LZ_W)) u_lzc (
      .in_vec   (s1_mag_q),
      .cnt      (lz_cnt),
      .all_zero (lz_zero)
   );

   // S2: normalise so the leading one sits in the top bit.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_sign_d  = s2_sign_q;
      s2_zero_d  = s2_zero_q;
      s2_norm_d  = s2_norm_q;
      s2_msb_d   = s2_msb_q;
      if (adv) begin
         s2_valid_d = s1_valid_q;
         s2_sign_d  = s1_sign_q;
         s2_zero_d  = s1_zero_q | lz_zero;
         s2_norm_d  = s1_mag_q << lz_cnt;
         s2_msb_d   = LZ_W'(INT_W - 1) - lz_cnt;
      end
   end

   // S3: bits below the hidden one, zero-padded so a narrow integer still
   // yields a full fraction plus guard and sticky positions.
   always_comb begin
      ext      = {s2_norm_q[INT_W-2:0], (MAN_W + 2)'(0)};
      frac     = ext[EXT_W-1 -: MAN_W];
      guard    = ext[EXT_W-1-MAN_W];
      sticky   = |ext[EXT_W-2-MAN_W:0];
      round_up = guard & (sticky | frac[0]);
      frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
      // A rounding carry leaves the fraction all-zero and bumps the exponent.
      exp_f    = EXP_W'(int'(s2_msb_q) + BIAS + int'(frac_sum[MAN_W]));
      is_zero  = s2_zero_q | ~s2_norm_q[INT_W-1];
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_inexact_d = out_inexact_q;
      if (adv) begin
         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            if (is_zero) begin
               out_data_d    = '0;
               out_inexact_d = 1'b0;
            end else begin
               out_data_d                  = '0;
               out_data_d[S_POS]           = s2_sign_q;
               out_data_d[S_POS-1:E_LSB]   = exp_f;
               out_data_d[MAN_W-1:0]       = frac_sum[MAN_W-1:0];
               out_inexact_d               = guard | sticky;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_mag_q      <= '0;
         s1_zero_q     <= 1'b0;
         s2_valid_q    <= 1'b0;
         s2_sign_q     <= 1'b0;
         s2_zero_q     <= 1'b0;
         s2_norm_q     <= '0;
         s2_msb_q      <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_inexact_q <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_sign_q     <= s1_sign_d;
         s1_mag_q      <= s1_mag_d;
         s1_zero_q     <= s1_zero_d;
         s2_valid_q    <= s2_valid_d;
         s2_sign_q     <= s2_sign_d;
         s2_zero_q     <= s2_zero_d;
         s2_norm_q     <= s2_norm_d;
         s2_msb_q      <= s2_msb_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_inexact_q <= out_inexact_d;
      end
   end

   assign in_ready    = adv;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_fp_pipe.sv
module tb_int_to_fp_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_inexact;
   logic [31:0] in_data, out_data;
   logic        s_in_valid, s_in_ready, s_in_signed, s_out_valid, s_out_ready, s_out_inexact;
   logic [15:0] s_in_data, s_out_data;

   int errors = 0;
   int checks = 0;

   int_to_fp_pipe #(.INT_W(32), .EXP_W(8), .MAN_W(23)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inexact(out_inexact)
   );

   int_to_fp_pipe #(.INT_W(16), .EXP_W(5), .MAN_W(10)) u_small (
      .clk(clk), .rst(rst),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_signed(s_in_signed),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_inexact(s_out_inexact)
   );

   // Reference: exact integer value rounded to MW+1 significant bits by
   // quotient/remainder arithmetic, ties to even.
   function automatic void ref_fp(input int iw, input int ew, input int mw,
                                  input longint unsigned d, input bit sgn,
                                  output longint unsigned res, output bit inexact);
      longint unsigned v, m, q, rem, half, be, s;
      int e, shift;
      bit neg;
      v = d & ((64'd1 << iw) - 1);
      neg = sgn && v[iw-1];
      m = neg ? ((64'd1 << iw) - v) : v;
      res = 0;
      inexact = 0;
      if (m == 0) return;
      e = 0;
      for (int b = 0; b < 64; b++) if (m[b]) e = b;
      if (e <= mw) begin
         q = m << (mw - e);
      end else begin
         shift = e - mw;
         q = m >> shift;
         rem = m - (q << shift);
         half = 64'd1 << (shift - 1);
         inexact = (rem != 0);
         if (rem > half || (rem == half && q[0])) q = q + 1;
      end
      if (q == (64'd1 << (mw + 1))) begin
         q = q >> 1;
         e = e + 1;
      end
      be = longint'(e + (1 << (ew - 1)) - 1);
      s = neg ? 64'd1 : 64'd0;
      res = (s << (ew + mw)) | (be << mw) | (q - (64'd1 << mw));
   endfunction

   task automatic run_one(input logic [31:0] d, input logic sg,
                          output logic [31:0] od, output logic oi, output int lat);
      in_data = d; in_signed = sg; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0; od = '0; oi = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (out_valid && lat == 0) begin
            lat = n; od = out_data; oi = out_inexact;
         end
      end
   endtask

   task automatic run_one_s(input logic [15:0] d, input logic sg,
                            output logic [15:0] od, output logic oi, output int lat);
      s_in_data = d; s_in_signed = sg; s_in_valid = 1'b1;
      @(posedge clk);
      #1 s_in_valid = 1'b0;
      lat = 0; od = '0; oi = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (s_out_valid && lat == 0) begin
            lat = n; od = s_out_data; oi = s_out_inexact;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      checks++; if (out_inexact !== 1'b0) begin errors++; $display("FAIL reset_inexact: got %b expected 0", out_inexact); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (s_out_valid !== 1'b0 || s_out_data !== 16'h0) begin
         errors++; $display("FAIL reset_small: got valid=%b data=%h expected 0/0", s_out_valid, s_out_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] td[8] = '{32'd1, 32'd16777217, 32'd16777219, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0};
      logic        ts[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] te[8] = '{32'h3F800000, 32'h4B800000, 32'h4B800002, 32'hBF800000,
                             32'h4F800000, 32'hCF000000, 32'h0, 32'h0};
      logic        ti[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] od;
      logic oi;
      int lat;
      for (int i = 0; i < 8; i++) begin
         run_one(td[i], ts[i], od, oi, lat);
         checks++; if (lat != 3) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 3", i, lat); end
         checks++; if (od !== te[i]) begin errors++; $display("FAIL directed_data[%0d] in=%h s=%b: got %h expected %h", i, td[i], ts[i], od, te[i]); end
         checks++; if (oi !== ti[i]) begin errors++; $display("FAIL directed_inexact[%0d]: got %b expected %b", i, oi, ti[i]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] d, od;
      logic sg, oi;
      int lat;
      longint unsigned r;
      bit ri;
      for (int i = 0; i < 40; i++) begin
         d = $urandom;
         if (i % 3 == 1) d = d >> $urandom_range(0, 31);
         sg = 1'($urandom_range(0, 1));
         ref_fp(32, 8, 23, 64'(d), sg, r, ri);
         run_one(d, sg, od, oi, lat);
         checks++; if (lat != 3 || od !== r[31:0] || oi !== ri) begin
            errors++;
            $display("FAIL random[%0d] in=%h s=%b: got %h/%b lat=%0d expected %h/%b lat=3", i, d, sg, od, oi, lat, r[31:0], ri);
         end
      end
   endtask

   task automatic test_small();
      logic [15:0] od, d;
      logic oi, sg;
      int lat;
      longint unsigned r;
      bit ri;
      run_one_s(16'd2049, 1'b0, od, oi, lat);
      checks++; if (lat != 3 || od !== 16'h6800 || oi !== 1'b1) begin
         errors++; $display("FAIL small_2049: got %h/%b lat=%0d expected 6800/1 lat=3", od, oi, lat);
      end
      run_one_s(16'h8000, 1'b1, od, oi, lat);
      checks++; if (lat != 3 || od !== 16'hF800 || oi !== 1'b0) begin
         errors++; $display("FAIL small_min_neg: got %h/%b lat=%0d expected f800/0 lat=3", od, oi, lat);
      end
      for (int i = 0; i < 20; i++) begin
         d = 16'($urandom);
         if (i % 4 == 2) d = d >> $urandom_range(0, 15);
         sg = 1'($urandom_range(0, 1));
         ref_fp(16, 5, 10, 64'(d), sg, r, ri);
         run_one_s(d, sg, od, oi, lat);
         checks++; if (lat != 3 || od !== r[15:0] || oi !== ri) begin
            errors++;
            $display("FAIL small_random[%0d] in=%h s=%b: got %h/%b lat=%0d expected %h/%b", i, d, sg, od, oi, lat, r[15:0], ri);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals[8];
      logic        sgs[8];
      logic [31:0] exp_d[$];
      logic        exp_i[$];
      logic [31:0] held_d, ed;
      logic        held_i, ei, stalled, go;
      int          got;
      longint unsigned r;
      bit ri;
      got = 0; stalled = 1'b0; held_d = '0; held_i = 1'b0; go = 1'b0;
      for (int i = 0; i < 8; i++) begin
         vals[i] = $urandom;
         sgs[i]  = 1'($urandom_range(0, 1));
         ref_fp(32, 8, 23, 64'(vals[i]), sgs[i], r, ri);
         exp_d.push_back(r[31:0]);
         exp_i.push_back(ri);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               in_valid = 1'b1; in_data = vals[i]; in_signed = sgs[i];
               go = 1'b0;
               for (int t = 0; t < 20 && !go; t++) begin
                  @(negedge clk);
                  go = in_ready;
                  @(posedge clk);
                  #1;
               end
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 1; c <= 6; c++) begin
               @(posedge clk);
               #1 out_ready = !(c >= 3 && c <= 5);
            end
         end
         begin
            for (int t = 0; t < 40 && got < 8; t++) begin
               @(negedge clk);
               if (stalled) begin
                  checks++;
                  if (out_valid !== 1'b1 || out_data !== held_d || out_inexact !== held_i) begin
                     errors++; $display("FAIL stall_hold: got %b/%h/%b expected 1/%h/%b", out_valid, out_data, out_inexact, held_d, held_i);
                  end
               end
               if (out_valid && !out_ready) begin
                  checks++;
                  if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
                  stalled = 1'b1; held_d = out_data; held_i = out_inexact;
               end else begin
                  stalled = 1'b0;
               end
               if (out_valid && out_ready) begin
                  checks++;
                  if (exp_d.size() == 0) begin
                     errors++; $display("FAIL b2b_extra: got %h expected no output", out_data);
                  end else begin
                     ed = exp_d.pop_front(); ei = exp_i.pop_front();
                     if (out_data !== ed || out_inexact !== ei) begin
                        errors++; $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b", got, out_data, out_inexact, ed, ei);
                     end
                  end
                  got++;
               end
            end
         end
      join
      out_ready = 1'b1;
      checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
      got = 0;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         if (out_valid) got++;
      end
      checks++; if (got != 0) begin errors++; $display("FAIL b2b_duplicate: got %0d extra outputs expected 0", got); end
   endtask

   task automatic test_mid_reset();
      logic [31:0] od;
      logic oi;
      int lat, stale;
      longint unsigned r;
      bit ri;
      @(posedge clk);
      #1 in_valid = 1'b1; in_data = 32'd5; in_signed = 1'b0;
      @(posedge clk);
      #1 in_data = 32'd7;
      @(posedge clk);
      #1 in_valid = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1 || out_data !== 32'h0) begin
         errors++; $display("FAIL midreset_state: got ready=%b data=%h expected 1/0", in_ready, out_data);
      end
      stale = 0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      checks++; if (stale != 0) begin errors++; $display("FAIL midreset_stale: got %0d outputs expected 0", stale); end
      ref_fp(32, 8, 23, 64'd3, 1'b0, r, ri);
      run_one(32'd3, 1'b0, od, oi, lat);
      checks++; if (lat != 3 || od !== r[31:0] || od !== 32'h40400000 || oi !== ri) begin
         errors++; $display("FAIL midreset_next: got %h/%b lat=%0d expected 40400000/0 lat=3", od, oi, lat);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_data = '0; s_in_signed = 1'b0; s_out_ready = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_small();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
